sw_debouncer: RTL and testbench

Single-channel switch conditioner that turns a raw, bouncing board switch into clean, clock-synchronous signals. It provides a debounced level plus one-cycle rising and falling pulses. It sits between a physical switch pin and any sequential logic (flip-flop, counter, FSM) that must never be clocked or enabled directly by a raw switch. Debouncing is done by a 4-state FSM with a stability counter.

---
 rtl/sw_debouncer.sv | 96 +++++++++
 tb/tb_sw_debouncer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// Switch conditioner: two-flop synchronizer, then a LOW/WAIT_H/HIGH/WAIT_L
// stability FSM that emits a clean level plus one-cycle rise/fall pulses.
module sw_debouncer #(
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_IN,
  output logic SW_LEVEL,
  output logic SW_RISE,
  output logic SW_FALL
);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    WAIT_H = 2'd1,
    HIGH   = 2'd2,
    WAIT_L = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= SW_IN;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter only advances while a WAIT state keeps seeing the new level;
  // every other path leaves it cleared, so it can never pass CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (s2_q) state_d = WAIT_H;
      end
      WAIT_H: begin
        if (!s2_q) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s2_q) state_d = WAIT_L;
      end
      WAIT_L: begin
        if (s2_q) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
    level_d = (state_d == HIGH) || (state_d == WAIT_L);
  end

  assign SW_LEVEL = level_q;
  assign SW_RISE  = rise_q;
  assign SW_FALL  = fall_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: two instances (CNT_MAX=4 and CNT_MAX=1) share one
// switch input and are checked every cycle against a run-length model.
module tb_sw_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic sw_in;
  logic level4, rise4, fall4;
  logic level1, rise1, fall1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sw_debouncer #(.CNT_MAX(4), .CNT_W(2)) dut4 (
    .CLK(clk), .RST(rst), .SW_IN(sw_in),
    .SW_LEVEL(level4), .SW_RISE(rise4), .SW_FALL(fall4)
  );

  sw_debouncer #(.CNT_MAX(1), .CNT_W(1)) dut1 (
    .CLK(clk), .RST(rst), .SW_IN(sw_in),
    .SW_LEVEL(level1), .SW_RISE(rise1), .SW_FALL(fall1)
  );

  // Model: a new level is accepted once the synchronized sample (the input
  // seen two edges earlier) has disagreed with the level CNT_MAX+1 times in a row.
  typedef struct {
    logic older;
    logic newer;
    logic level;
    logic rise;
    logic fall;
    int   run;
  } model_t;

  model_t m4, m1;

  function automatic model_t model_step(model_t m, logic sw, int cmax);
    model_t n  = m;
    logic   s2 = m.older;
    n.older = m.newer;
    n.newer = sw;
    n.rise  = 1'b0;
    n.fall  = 1'b0;
    if (s2 != m.level) begin
      n.run = m.run + 1;
      if (n.run == cmax + 1) begin
        n.level = s2;
        n.rise  = s2;
        n.fall  = !s2;
        n.run   = 0;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= '{older: 1'b0, newer: 1'b0, level: 1'b0, rise: 1'b0, fall: 1'b0, run: 0};
      m1 <= '{older: 1'b0, newer: 1'b0, level: 1'b0, rise: 1'b0, fall: 1'b0, run: 0};
    end else begin
      m4 <= model_step(m4, sw_in, 4);
      m1 <= model_step(m1, sw_in, 1);
    end
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("model_level4", level4, m4.level);
    check_output("model_rise4",  rise4,  m4.rise);
    check_output("model_fall4",  fall4,  m4.fall);
    check_output("model_level1", level1, m1.level);
    check_output("model_rise1",  rise1,  m1.rise);
    check_output("model_fall1",  fall1,  m1.fall);
  end

  task automatic apply_stimulus(input logic v, input int n);
    sw_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Expect exactly one rise on edge 7 of a steady 1 (CNT_MAX=4), no fall.
  task automatic expect_rise4(input string tag);
    sw_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check_output({tag, "_rise4"},  rise4,  e == 7);
      check_output({tag, "_level4"}, level4, e >= 7);
      check_output({tag, "_fall4"},  fall4,  1'b0);
    end
  endtask

  task automatic reset_mid_cycle(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_output({tag, "_async_level4"}, level4, 1'b0);
    check_output({tag, "_async_rise4"},  rise4,  1'b0);
    check_output({tag, "_async_fall4"},  fall4,  1'b0);
    check_output({tag, "_async_level1"}, level1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_level4", level4, 1'b0);
    check_output("reset_rise4",  rise4,  1'b0);
    check_output("reset_fall4",  fall4,  1'b0);
    check_output("reset_level1", level1, 1'b0);
    check_output("reset_rise1",  rise1,  1'b0);
    check_output("reset_fall1",  fall1,  1'b0);
    rst = 1'b0;
    apply_stimulus(1'b0, 3);

    $display("[TB] clean rise");
    sw_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check_output("clean_rise4",  rise4,  e == 7);
      check_output("clean_level4", level4, e >= 7);
      check_output("clean_fall4",  fall4,  1'b0);
      check_output("clean_rise1",  rise1,  e == 4);
    end
    apply_stimulus(1'b1, 4);

    $display("[TB] clean fall");
    sw_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      check_output("clean_fall4",   fall4,  e == 7);
      check_output("clean_flevel4", level4, e < 7);
      check_output("clean_frise4",  rise4,  1'b0);
    end
    apply_stimulus(1'b0, 4);

    $display("[TB] bounce rejection");
    repeat (5) begin
      sw_in = 1'b1;
      for (int e = 0; e < 4; e++) begin
        if (e == 3) sw_in = 1'b0;
        @(negedge clk);
        check_output("bounce_level4", level4, 1'b0);
        check_output("bounce_rise4",  rise4,  1'b0);
      end
    end
    expect_rise4("bounce_hold");
    apply_stimulus(1'b1, 4);

    $display("[TB] glitch while high");
    for (int e = 1; e <= 10; e++) begin
      sw_in = (e > 2);
      @(negedge clk);
      check_output("glitch_level4", level4, 1'b1);
      check_output("glitch_rise4",  rise4,  1'b0);
      check_output("glitch_fall4",  fall4,  1'b0);
    end

    $display("[TB] async reset mid WAIT_H");
    apply_stimulus(1'b0, 12);
    apply_stimulus(1'b1, 4);
    reset_mid_cycle("waith");
    expect_rise4("waith_restart");

    $display("[TB] async reset while high");
    apply_stimulus(1'b1, 4);
    reset_mid_cycle("high");
    expect_rise4("high_restart");

    $display("[TB] CNT_MAX=1 boundary");
    apply_stimulus(1'b0, 12);
    for (int e = 1; e <= 8; e++) begin
      sw_in = (e <= 2);
      @(negedge clk);
      check_output("c1_two_rise1",  rise1,  e == 4);
      check_output("c1_two_level1", level1, (e == 4) || (e == 5));
      check_output("c1_two_fall1",  fall1,  e == 6);
      check_output("c1_two_level4", level4, 1'b0);
    end
    apply_stimulus(1'b0, 4);
    for (int e = 1; e <= 8; e++) begin
      sw_in = (e == 1);
      @(negedge clk);
      check_output("c1_one_rise1",  rise1,  1'b0);
      check_output("c1_one_level1", level1, 1'b0);
    end

    $display("[TB] randomized runs");
    for (int r = 0; r < 300; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) begin
        sw_in = v;
        if ($urandom_range(0, 199) == 0) begin
          #1 rst = 1'b1;
          #2 rst = 1'b0;
        end
        @(negedge clk);
      end
    end
    apply_stimulus(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
